// File: rtl/csa_seq_adder_ctrl.sv
// csa_seq_adder_ctrl: adds two WIDTH-bit operands one SLICE-bit carry-skip
// slice per clock, LSB-first, behind valid/ready handshakes on both sides.
module csa_seq_adder_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned NGRP   = SLICE / 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_co, sl_cmsb, chain_c, grp_cin, rpl_c, grp_p, bx;
  logic              last_c;

  assign last_c = (idx_q == IDXW'(NSLICE - 1));

  // Carry-skip slice: 4-bit ripple groups, group carry bypassed when all bits propagate
  always_comb begin
    sl_a    = '0;
    sl_b    = '0;
    sl_sum  = '0;
    sl_cmsb = 1'b0;
    grp_cin = 1'b0;
    rpl_c   = 1'b0;
    grp_p   = 1'b0;
    bx      = 1'b0;
    for (int s = 0; s < int'(NSLICE); s++) begin
      if (idx_q == IDXW'(s)) begin
        sl_a = a_q[s*SLICE +: SLICE];
        sl_b = b_q[s*SLICE +: SLICE];
      end
    end
    chain_c = carry_q;
    for (int g = 0; g < int'(NGRP); g++) begin
      grp_cin = chain_c;
      rpl_c   = chain_c;
      grp_p   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bx = sl_a[g*4+i] ^ sl_b[g*4+i];
        if ((g*4+i) == int'(SLICE) - 1) sl_cmsb = rpl_c;
        sl_sum[g*4+i] = bx ^ rpl_c;
        grp_p = grp_p & bx;
        rpl_c = (sl_a[g*4+i] & sl_b[g*4+i]) | (bx & rpl_c);
      end
      chain_c = grp_p ? grp_cin : rpl_c;
    end
    sl_co = chain_c;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_c)    state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath next values: operand capture on accept, one slice per RUN cycle
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        for (int s = 0; s < int'(NSLICE); s++) begin
          if (idx_q == IDXW'(s)) sum_d[s*SLICE +: SLICE] = sl_sum;
        end
        carry_d = sl_co;
        idx_d   = idx_q + IDXW'(1);
        if (last_c) begin
          cout_d = sl_co;
          ovf_d  = sl_cmsb ^ sl_co;
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
